freq_meter: RTL

- Measures the frequency of an external asynchronous square wave by counting its rising edges over a fixed gate window of `GATE_CYCLES` system clocks.
- Reports the count per window, so a 1 s window at 100 MHz gives Hz directly.
- Performs the inverse job of the team's clock divider: it measures a slow clock against the system clock instead of generating one.
- Feeds the 7-segment display path and self-checks divider outputs on the board.

---
 rtl/freq_meter_pkg.sv | 24 ++
 rtl/sync_edge_det.sv | 32 +++
 rtl/freq_meter.sv | 117 +++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and helpers for the frequency meter
// Purpose: gate-window state encoding and the saturating increment used by
//          the edge counter. No ports.
package freq_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  // Widest counter the helper supports; callers cast to/from their own width.
  localparam int unsigned SAT_W = 64;

  // Add inc to val, but never step past max_val.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val,
                                               input logic             inc);
    if (inc && (val != max_val)) begin
      return val + SAT_W'(1);
    end
    return val;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - synchronizer plus rising-edge detector for async inputs
// Purpose: bring an asynchronous level into the clk domain and flag its rising edges.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   async_in in   asynchronous level
//   rise     out  one-cycle pulse per synchronized rising edge
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - counts rising edges of an async signal per gate window
// Purpose: report the number of sig_in rising edges seen in each window of
//          GATE_CYCLES clk cycles, with saturation/overflow reporting.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sig_in     in   asynchronous signal being measured
//   en         in   level enable, measure continuously while high
//   freq       out  edge count of the last completed window
//   freq_valid out  one-cycle pulse when freq/overflow update
//   overflow   out  last completed window saturated the counter
//   busy       out  a gate window is in progress
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned      GC_W      = $clog2(GATE_CYCLES);
  localparam logic [GC_W-1:0]  GATE_LAST = GC_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t            state_q;
  state_t            state_d;
  logic [GC_W-1:0]   gate_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic              sat_q;
  logic              rise;
  logic              last_cycle;
  logic [CNT_W-1:0]  edge_next;
  logic              inc_at_max;

  // Runs in every state so the first window never sees a stale edge.
  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(sig_in),
    .rise    (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en) state_d = GATE;
      GATE: begin
        if (last_cycle) begin
          state_d = en ? GATE : IDLE;
        end else if (!en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == GATE);
    last_cycle = (state_q == GATE) && (gate_cnt_q == GATE_LAST);
  end

  assign edge_next  = CNT_W'(sat_inc(SAT_W'(edge_cnt_q), SAT_W'(CNT_MAX), rise));
  assign inc_at_max = rise && (edge_cnt_q == CNT_MAX);

  // The last gate cycle's own edge is folded into the published result, and
  // the counters restart so a following window begins with no dead cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq       <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (last_cycle) begin
        freq       <= edge_next;
        overflow   <= sat_q | inc_at_max;
        freq_valid <= 1'b1;
        gate_cnt_q <= '0;
        edge_cnt_q <= '0;
        sat_q      <= 1'b0;
      end else if ((state_q == GATE) && en) begin
        gate_cnt_q <= gate_cnt_q + GC_W'(1);
        edge_cnt_q <= edge_next;
        sat_q      <= sat_q | inc_at_max;
      end else begin
        // Idle or aborting: a partial window is discarded.
        gate_cnt_q <= '0;
        edge_cnt_q <= '0;
        sat_q      <= 1'b0;
      end
    end
  end

endmodule
